// File: rtl/ram_ctrl.sv
// Controller for a 32x8 synchronous single-port RAM. It serves single-word
// read/write requests over a valid/ready handshake and can sweep the whole
// memory to a fixed clear value. All RAM-side outputs decode from registered
// state only, so requester inputs never reach the RAM combinationally.
module ram_ctrl #(
    parameter logic [7:0] CLR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,

    // Requester side
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       clr_start,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       clr_done,
    output logic       busy,

    // RAM side
    output logic       mem_cs,
    output logic       mem_wrt,
    output logic       mem_rd,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRcap,
        StClr
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;
    logic [7:0] resp_rdata_q, resp_rdata_d;
    logic       resp_valid_q, resp_valid_d;
    logic       clr_done_q, clr_done_d;

    logic       idle;

    assign idle = (state_q == StIdle);

    // Ready is gated by rst so nothing is advertised while outputs are held
    // in reset; a clear request takes priority over a pending access.
    assign req_ready  = ~rst & idle & ~clr_start;
    assign busy       = ~idle;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign clr_done   = clr_done_q;

    // Next-state, request latching, sweep counter and response capture
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        clr_cnt_d    = clr_cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_valid_d = 1'b0;
        clr_done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d   = StClr;
                    clr_cnt_d = 5'd0;
                end else if (req_valid) begin
                    addr_d = req_addr;
                    if (req_we) begin
                        wdata_d = req_wdata;
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                state_d = StIdle;
            end
            StRd: begin
                state_d = StRcap;
            end
            StRcap: begin
                // RAM output is stable here because cs is low this cycle
                resp_rdata_d = mem_rdata;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StClr: begin
                // Leave on the last address rather than letting the counter wrap
                if (clr_cnt_q == 5'd31) begin
                    state_d    = StIdle;
                    clr_cnt_d  = 5'd0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= 5'd0;
            wdata_q      <= 8'h00;
            clr_cnt_q    <= 5'd0;
            resp_rdata_q <= 8'h00;
            resp_valid_q <= 1'b0;
            clr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            clr_cnt_q    <= clr_cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_valid_q <= resp_valid_d;
            clr_done_q   <= clr_done_d;
        end
    end

    // RAM strobes decoded purely from registered state
    always_comb begin
        mem_cs    = 1'b0;
        mem_wrt   = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = 5'd0;
        mem_wdata = 8'h00;

        unique case (state_q)
            StWr: begin
                mem_cs    = 1'b1;
                mem_wrt   = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            StRd: begin
                mem_cs   = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = addr_q;
            end
            StClr: begin
                mem_cs    = 1'b1;
                mem_wrt   = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = CLR_VALUE;
            end
            default: begin
                mem_cs = 1'b0;
            end
        endcase
    end

`ifndef SYNTHESIS
    strobe_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_wrt && mem_rd));
    sweep_ends: assert property (@(posedge clk) disable iff (rst)
        (state_q == StClr && clr_cnt_q == 5'd31) |=> (state_q == StIdle));
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl with a behavioural 32x8 RAM and a
// scoreboard of expected read responses.
module tb_ram_ctrl;

    localparam logic [7:0] CLR_V = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [4:0] req_addr = 5'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       clr_start = 1'b0;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       clr_done;
    logic       busy;
    logic       mem_cs;
    logic       mem_wrt;
    logic       mem_rd;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    logic [7:0] ram [32];

    typedef struct packed {
        logic [7:0] data;
        int         cyc;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t mon_e;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int clr_done_cnt = 0;

    ram_ctrl #(.CLR_VALUE(CLR_V)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .clr_start  (clr_start),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .clr_done   (clr_done),
        .busy       (busy),
        .mem_cs     (mem_cs),
        .mem_wrt    (mem_wrt),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAM; output holds while cs is low
    always @(posedge clk) begin
        if (mem_cs && mem_wrt) ram[mem_addr] <= mem_wdata;
        if (mem_cs && mem_rd) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every resp_valid
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_rdata", {24'd0, resp_rdata}, {24'd0, mon_e.data});
                    check("resp_latency", cyc - mon_e.cyc, 32'd2);
                end
            end
            if (clr_done) clr_done_cnt++;
            if (mem_cs) check("strobe_excl", {31'd0, mem_wrt & mem_rd}, 32'd0);
        end
    end

    // Called at negedge+1 with a request driven; waits boundedly for ready
    task automatic wait_ready();
        for (int i = 0; i < 100 && !req_ready; i++) begin
            @(negedge clk);
            #1;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        #1;
        wait_ready();
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("wr_strobe", {mem_cs, mem_wrt, mem_rd, mem_addr, mem_wdata},
              {1'b1, 1'b1, 1'b0, addr, data});
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [7:0] exp, input bit hold);
        sb_entry_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        #1;
        wait_ready();
        @(posedge clk);
        #1;
        e.data = exp;
        e.cyc  = cyc;
        sb.push_back(e);
        if (!hold) req_valid = 1'b0;
        @(negedge clk);
        check("rd_strobe", {mem_cs, mem_wrt, mem_rd, mem_addr, req_ready},
              {1'b1, 1'b0, 1'b1, addr, 1'b0});
        @(negedge clk);
        check("rcap_state", {mem_cs, mem_wrt, mem_rd, req_ready, busy},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        req_valid = 1'b0;
        if (hold) begin
            @(negedge clk);
            check("no_reaccept", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic do_clear();
        int start_cnt;
        logic [4:0] a5;
        @(negedge clk);
        clr_start = 1'b1;
        #1 check("clr_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 clr_start = 1'b0;
        start_cnt = clr_done_cnt;
        for (int i = 0; i < 32; i++) begin
            a5 = 5'(i);
            @(negedge clk);
            check("clr_sweep", {busy, mem_cs, mem_wrt, mem_rd, mem_addr, mem_wdata, clr_done},
                  {1'b1, 1'b1, 1'b1, 1'b0, a5, CLR_V, 1'b0});
        end
        @(negedge clk);
        check("clr_done", {clr_done, busy, mem_cs}, {1'b1, 1'b0, 1'b0});
        @(negedge clk);
        check("clr_done_width", {31'd0, clr_done}, 32'd0);
        check("clr_done_count", clr_done_cnt - start_cnt, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {req_ready, resp_valid, resp_rdata, clr_done, busy, mem_cs, mem_wrt, mem_rd,
                    mem_addr, mem_wdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int done0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        #1 check("ready_after_reset", {req_ready, busy}, {1'b1, 1'b0});

        // Basic write then read with latency
        do_write(5'h1B, 8'h24);
        do_read(5'h1B, 8'h24, 1'b0);

        // Two writes, two reads
        do_write(5'h0A, 8'h36);
        do_write(5'h1B, 8'h68);
        do_read(5'h0A, 8'h36, 1'b0);
        do_read(5'h1B, 8'h68, 1'b0);

        // Requester holds valid through a read
        do_read(5'h1B, 8'h68, 1'b1);

        // Full clear then readback
        do_clear();
        do_read(5'h1B, CLR_V, 1'b0);

        // Clear and write requested together: clear wins
        @(negedge clk);
        clr_start = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'h05;
        req_wdata = 8'hAA;
        #1 check("prio_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 clr_start = 1'b0;
        @(negedge clk);
        check("prio_clr_first", {busy, mem_cs, mem_wrt, mem_addr, req_ready},
              {1'b1, 1'b1, 1'b1, 5'd0, 1'b0});
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (clr_done) found = 1'b1;
        end
        check("prio_clr_done_seen", {31'd0, found}, 32'd1);
        check("prio_ready_after", {req_ready, mem_cs}, {1'b1, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("prio_write", {mem_cs, mem_wrt, mem_addr, mem_wdata},
              {1'b1, 1'b1, 5'h05, 8'hAA});
        do_read(5'h05, 8'hAA, 1'b0);

        // Reset in the middle of a sweep
        for (int a = 0; a < 32; a++) do_write(5'(a), 8'(a) ^ 8'hC3);
        @(negedge clk);
        clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
        done0 = clr_done_cnt;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (mem_addr == 5'h10) found = 1'b1;
        end
        check("sweep_reached_0x10", {31'd0, found}, 32'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_sweep_reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_mid_reset", {req_ready, busy}, {1'b1, 1'b0});
        repeat (3) @(negedge clk);
        check("no_clr_done_after_abort", clr_done_cnt - done0, 32'd0);
        for (int a = 0; a < 32; a++) begin
            do_read(5'(a), (a < 16) ? CLR_V : (8'(a) ^ 8'hC3), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter: CLR_VALUE, default 8'h00, data word written to every location by a clear sweep.
REQ-002 clk  in  1  clock; all registers update on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  requester presents an access.
REQ-005 req_ready  out  1  controller can accept an access this cycle.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  5  word address, 0..31.
REQ-008 req_wdata  in  8  write data.
REQ-009 clr_start  in  1  request a full-memory clear sweep.
REQ-010 resp_valid  out  1  one-cycle pulse: resp_rdata carries read data.
REQ-011 resp_rdata  out  8  last read data; held until the next read completes.
REQ-012 clr_done  out  1  one-cycle pulse at the end of a sweep.
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 mem_cs, mem_wrt, mem_rd  out  1 each  chip select, write strobe and read strobe to the 32x8 RAM.
REQ-015 mem_addr  out  5  RAM address.
REQ-016 mem_wdata  out  8  RAM write data.
REQ-017 mem_rdata  in  8  RAM read data, valid the cycle after a rising edge that sampled cs=1, rd=1.

Function
REQ-018 FSM states SHALL be IDLE, WR, RD, RCAP and CLR; no other states.
REQ-019 req_ready SHALL be 1 only in IDLE with clr_start=0.
REQ-020 Acceptance SHALL occur on a rising edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata are latched on that edge.
REQ-021 Transitions:
- IDLE->CLR when clr_start=1 (priority over req_valid).
- IDLE->WR on accepted write.
- IDLE->RD on accepted read.
- WR->IDLE.
- RD->RCAP.
- RCAP->IDLE.
- CLR->IDLE after address 31.
REQ-022 WR SHALL drive mem_cs=1, mem_wrt=1, mem_rd=0, mem_addr=latched address and mem_wdata=latched data for exactly one cycle.
REQ-023 RD SHALL drive mem_cs=1, mem_rd=1, mem_wrt=0 and mem_addr=latched address for exactly one cycle.
REQ-024 RCAP SHALL drive mem_cs=0 so the RAM holds its output. On the edge leaving RCAP: resp_rdata <= mem_rdata, resp_valid <= 1.
REQ-025 Read latency: resp_valid SHALL be high in the cycle following the 2nd rising edge after the acceptance edge.
REQ-026 Throughput: one read per 3 cycles, one write per 2 cycles.
REQ-027 Writes SHALL produce no resp_valid.
REQ-028 CLR SHALL write CLR_VALUE to addresses 0,1,...,31 in ascending order, one per cycle (mem_cs=1, mem_wrt=1), for exactly 32 cycles using a 5-bit sweep counter.
REQ-029 clr_done SHALL pulse for one cycle on entering IDLE from CLR. The sweep counter SHALL NOT wrap into a 33rd write.
REQ-030 Outside WR, RD and CLR: mem_cs=0, mem_wrt=0 and mem_rd=0. mem_wrt and mem_rd SHALL never both be 1.
REQ-031 mem_* outputs SHALL depend only on registered state; there is no combinational path from req_* or clr_start to mem_*.
REQ-032 clr_start and req_valid SHALL be ignored while busy=1; an unaccepted request stays pending at the requester.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, irrespective of clk, and clear every output to 0, including resp_rdata=8'h00, mem_addr=0 and mem_wdata=0.
REQ-034 A reset in WR, RD, RCAP or CLR SHALL abort the operation with no further RAM strobes, drop any latched request, and leave RAM contents untouched (this block does not drive RAM reset).
REQ-035 req_ready SHALL become 1 on the first cycle after rst deasserts.

Verification
REQ-036 After reset: write 0x1B<-0x24, then read 0x1B -> resp_rdata=8'h24, resp_valid exactly 2 edges after acceptance, one cycle wide.
REQ-037 Write 0x0A<-0x36 and 0x1B<-0x68, then read 0x0A and 0x1B -> 8'h36, then 8'h68; mem_cs low during both RCAP cycles.
REQ-038 Pulse clr_start -> busy high 32 cycles, mem_addr 0..31, one clr_done pulse; then read 0x1B -> 8'h00.
REQ-039 clr_start and req_valid (write 0x05<-0xAA) high together in IDLE -> clear runs first with req_ready=0; the write is accepted on the first IDLE edge after clr_done; readback of 0x05 gives 8'hAA.
REQ-040 Assert rst mid-sweep at mem_addr=0x10 -> same-cycle IDLE, all outputs 0, no clr_done. Addresses 0x00-0x0F read back CLR_VALUE; 0x10-0x1F keep their prior data.
REQ-041 Hold req_valid through a read -> req_ready low in RD and RCAP, no second acceptance before IDLE.
